// File: rtl/led_trail_pkg.sv
// Shared constants and types for the led_trail LED comet-trail output stage.
package led_trail_pkg;

  localparam int LED_W       = 8;
  localparam int LED_LEVEL_W = 3;

  typedef logic [LED_LEVEL_W-1:0] led_level_t;

  localparam led_level_t LED_LEVEL_MAX = '1;

endpackage

// File: rtl/trail_channel.sv
// One LED channel of led_trail: holds a brightness level, loads/fades it and
// drives the LED by comparing the level against the shared PWM counter.
module trail_channel
  import led_trail_pkg::*;
#(
  parameter int LEVEL_W = LED_LEVEL_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               step,
  input  logic               load,
`ifdef LED_TRAIL_DECAY_EN
  input  logic               hold,
  input  logic               decay,
`endif
  input  logic               enable,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               led
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] level_d;

  // NOTE: level_d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    level_d = level;
`ifdef LED_TRAIL_DECAY_EN
    if (decay && !hold && (level != '0)) level_d = level - 1'b1;
    if (step && load)                    level_d = LEVEL_MAX;
`else
    if (step) level_d = load ? LEVEL_MAX : '0;
`endif
  end

  // Full level means 100 % duty; any other level k lights for k of every period.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      level <= level_d;
      led   <= enable & ((level == LEVEL_MAX) | (level > pwm_cnt));
    end
  end

endmodule

// File: rtl/led_trail.sv
// LED output stage: full-brightness current dot with a PWM-faded comet trail.
// Define LED_TRAIL_DECAY_EN to enable the fading trail; otherwise unlit LEDs go dark at once.
module led_trail
  import led_trail_pkg::*;
#(
  parameter int WIDTH     = LED_W,
  parameter int LEVEL_W   = LED_LEVEL_W,
  parameter int DECAY_DIV = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] pattern,
  input  logic             enable,
  output logic [WIDTH-1:0] led,
  output logic             frame
);

  localparam logic [LEVEL_W-1:0] PWM_LAST = '1;

  if (DECAY_DIV < 1) begin : g_bad_decay_div
    $error("led_trail: DECAY_DIV must be at least 1");
  end

  logic [LEVEL_W-1:0] pwm_cnt;
  logic               period_tick;

  assign period_tick = enable && (pwm_cnt == PWM_LAST);

  // NOTE: clocked state uses <= so every flop samples pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pwm_cnt <= '0;
      frame   <= 1'b0;
    end else begin
      if (enable) pwm_cnt <= pwm_cnt + 1'b1;
      frame <= period_tick;
    end
  end

`ifdef LED_TRAIL_DECAY_EN
  localparam int DECAY_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_DIV - 1);

  logic [DECAY_W-1:0] decay_cnt;
  logic               decay_tick;
  logic [WIDTH-1:0]   cur_pat;
  logic [WIDTH-1:0]   hold_pat;

  assign decay_tick = period_tick && (decay_cnt == DECAY_LAST);
  // A step coinciding with a decay tick judges decay against the incoming pattern.
  assign hold_pat   = step ? pattern : cur_pat;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      decay_cnt <= '0;
      cur_pat   <= '0;
    end else begin
      if (period_tick) decay_cnt <= decay_tick ? '0 : decay_cnt + 1'b1;
      if (step)        cur_pat   <= pattern;
    end
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    trail_channel #(
      .LEVEL_W (LEVEL_W)
    ) u_ch (
      .clk     (clk),
      .clear   (clear),
      .step    (step),
      .load    (pattern[i]),
`ifdef LED_TRAIL_DECAY_EN
      .hold    (hold_pat[i]),
      .decay   (decay_tick),
`endif
      .enable  (enable),
      .pwm_cnt (pwm_cnt),
      .led     (led[i])
    );
  end

endmodule

// File: tb/tb_led_trail.sv
// Self-checking bench for led_trail: per-cycle scoreboard against a behavioural
// model, plus duty-cycle and blanking checks with constant expectations.
module tb_led_trail;
  import led_trail_pkg::*;

  localparam int W    = LED_W;
  localparam int MAXL = int'(LED_LEVEL_MAX);
  localparam int PER  = MAXL + 1;
  localparam int DIV  = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic         step;
  logic         enable;
  logic [W-1:0] pattern;
  logic [W-1:0] led;
  logic         frame;

  int checks = 0;
  int errors = 0;

  logic [W:0] sb[$];

  int           m_pwm;
  int           m_dcnt;
  int           m_lvl[W];
  logic [W-1:0] m_cur;
  bit           m_last_dtick;

  led_trail #(
    .WIDTH     (W),
    .LEVEL_W   (LED_LEVEL_W),
    .DECAY_DIV (DIV)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .step    (step),
    .pattern (pattern),
    .enable  (enable),
    .led     (led),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pwm  = 0;
    m_dcnt = 0;
    m_cur  = '0;
    m_last_dtick = 1'b0;
    for (int i = 0; i < W; i++) m_lvl[i] = 0;
  endtask

  // One clock: drive inputs, push expected outputs, advance model, sample and compare.
  task automatic tick(input logic s, input logic [W-1:0] p, input logic en);
    logic [W-1:0] e_led;
    logic [W:0]   got_exp;
    logic [W-1:0] judge;
    bit           period;
    bit           dt;
    step    = s;
    pattern = p;
    enable  = en;
    for (int i = 0; i < W; i++)
      e_led[i] = en && ((m_lvl[i] == MAXL) || (m_lvl[i] > m_pwm));
    sb.push_back({e_led, (en && (m_pwm == MAXL))});
    period = en && (m_pwm == MAXL);
`ifdef LED_TRAIL_DECAY_EN
    dt = period && (m_dcnt == DIV - 1);
    if (period) m_dcnt = dt ? 0 : m_dcnt + 1;
    judge = s ? p : m_cur;
    for (int i = 0; i < W; i++) begin
      if (s && p[i])                          m_lvl[i] = MAXL;
      else if (dt && !judge[i] && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
    end
    if (s) m_cur = p;
`else
    dt    = 1'b0;
    judge = '0;
    for (int i = 0; i < W; i++)
      if (s) m_lvl[i] = p[i] ? MAXL : 0;
`endif
    if (en) m_pwm = (m_pwm + 1) % PER;
    m_last_dtick = dt;
    @(posedge clk);
    #1;
    got_exp = sb.pop_front();
    check("led", led, got_exp[W:1]);
    check("frame", frame, got_exp[0]);
    step = 1'b0;
  endtask

  // Run n idle cycles, counting high samples of led[0], led[1], led[W-1:2] and frame.
  task automatic run(input int n, input logic en,
                     output int c0, output int c1, output int crest, output int cf);
    c0 = 0; c1 = 0; crest = 0; cf = 0;
    for (int k = 0; k < n; k++) begin
      tick(1'b0, '0, en);
      c0    += int'(led[0]);
      c1    += int'(led[1]);
      crest += (led[W-1:2] != '0) ? 1 : 0;
      cf    += int'(frame);
    end
  endtask

  task automatic wait_dtick();
    bit done = 1'b0;
    for (int n = 0; n < 2 * DIV * PER && !done; n++) begin
      tick(1'b0, '0, 1'b1);
      done = m_last_dtick;
    end
  endtask

  initial begin
    int c0, c1, cr, cf;
    step    = 1'b0;
    enable  = 1'b0;
    pattern = '0;
    clear   = 1'b0;
    model_reset();

    // Reset state
    #1 clear = 1'b1;
    #2;
    check("reset_led", led, '0);
    check("reset_frame", frame, 1'b0);
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;

    // Single dot
    tick(1'b1, 8'h01, 1'b1);
    run(16, 1'b1, c0, c1, cr, cf);
    check("dot_led0_on", c0, 16);
    check("dot_led1_off", c1, 0);
    check("dot_rest_off", cr, 0);
    check("dot_frames", cf, 2);

    // Async clear mid-cycle, no edge needed
    #2 clear = 1'b1;
    #1;
    check("clear_led", led, '0);
    check("clear_frame", frame, 1'b0);
    model_reset();
    #2 clear = 1'b0;
    run(10, 1'b1, c0, c1, cr, cf);
    check("post_clear_dark", c0 + c1 + cr, 0);

`ifdef LED_TRAIL_DECAY_EN
    // Fade: led[0] steps down one duty level per decay tick
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b1, 8'h02, 1'b1);
    for (int k = MAXL - 1; k >= 0; k--) begin
      wait_dtick();
      run(PER, 1'b1, c0, c1, cr, cf);
      check($sformatf("fade_duty_%0d", k), c0, k);
      check($sformatf("fade_led1_%0d", k), c1, PER);
    end

    // Collision: load beats decay on led[0], led[1] still decays
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b1, 8'h02, 1'b1);
    for (int n = 0; n < 8 && m_lvl[0] != 3; n++) wait_dtick();
    check("collide_pre_duty", 32'(m_lvl[0]), 3);
    for (int n = 0; n < 2 * DIV * PER && !(m_pwm == MAXL && m_dcnt == DIV - 1); n++)
      tick(1'b0, '0, 1'b1);
    tick(1'b1, 8'h01, 1'b1);
    run(PER, 1'b1, c0, c1, cr, cf);
    check("collide_led0_full", c0, PER);
    check("collide_led1_decay", c1, MAXL - 1);

    // Set up a mid-fade level for blanking
    tick(1'b1, 8'h02, 1'b1);
    wait_dtick();
`else
    // No trail: the old dot goes dark on the cycle after the next step
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b1, 8'h02, 1'b1);
    run(16, 1'b1, c0, c1, cr, cf);
    check("notrail_led0_off", c0, 0);
    check("notrail_led1_on", c1, 16);
`endif

    // Blanking holds all state and darkens outputs
    run(20, 1'b0, c0, c1, cr, cf);
    check("blank_leds", c0 + c1 + cr, 0);
    check("blank_frames", cf, 0);
    run(PER, 1'b1, c0, c1, cr, cf);
`ifdef LED_TRAIL_DECAY_EN
    check("resume_led0_duty", c0, MAXL - 1);
`else
    check("resume_led0_duty", c0, 0);
`endif
    check("resume_led1_full", c1, PER);
    check("resume_frames", cf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_trail.md
# led_trail

Output stage that sits directly downstream of the bouncing-pattern shifter/register datapath. It consumes the 8-bit one-hot LED pattern and a step strobe, and drives the physical LEDs. The currently lit position is driven at full brightness; previously lit positions fade out over time through per-LED PWM, giving a comet trail behind the bouncing dot.

## Interface
- `WIDTH`, default 8: number of LEDs / pattern bits.
- `LEVEL_W`, default 3: brightness bits per LED; sets PWM period to 2^LEVEL_W cycles.
- `DECAY_DIV`, default 4: PWM periods per one-level decay step; legal range ≥1.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `clear`  in  1  asynchronous, active-high reset.
- `step`  in  1  single-cycle pulse; `pattern` holds a new value this cycle.
- `pattern`  in  WIDTH  LED pattern from the upstream register; normally one-hot, any value legal.
- `enable`  in  1  run/blank control.
- `led`  out  WIDTH  registered LED drive.
- `frame`  out  1  registered single-cycle pulse at each PWM period start.

## Operation
- State:
  - `pwm_cnt` (LEVEL_W bits).
  - `decay_cnt` (counts 0..DECAY_DIV-1).
  - `cur_pat` (WIDTH bits).
  - `level[i]` (LEVEL_W bits each).
- Reset: all state 0; `led` = 0, `frame` = 0.
- PWM counter:
  - `pwm_cnt` increments by 1 each cycle while `enable` = 1.
  - It wraps from 2^LEVEL_W-1 to 0.
  - A wrap is a "period tick".
- Decay counter:
  - On a period tick, `decay_cnt` increments.
  - At DECAY_DIV-1 it returns to 0 and raises a one-cycle internal decay tick.
- Step handling (independent of `enable`):
  - On `step`, `cur_pat` ← `pattern`.
  - Every bit set in `pattern` loads `level[i]` ← LEVEL_MAX (2^LEVEL_W-1).
- Decay:
  - On a decay tick, every `level[i]` with `cur_pat[i]` = 0 and `level[i]` ≠ 0 decrements by 1.
  - Levels saturate at 0.
  - Bits held in `cur_pat` never decay.
- Simultaneous `step` and decay tick:
  - Load wins for bits set in the new `pattern`.
  - All other bits decay, judged against the new pattern.
- LED drive, next state: `led[i]` = `enable` & ((`level[i]` == LEVEL_MAX) | (`level[i]` > `pwm_cnt`)).
  - LEVEL_MAX gives 100 % duty.
  - Level k < LEVEL_MAX gives k/2^LEVEL_W duty.
  - Level 0 gives 0 % duty.
- Disabled (`enable` = 0):
  - `pwm_cnt`, `decay_cnt` and levels hold, except for step loads.
  - `led` = 0 and `frame` = 0 from the next edge.
- `frame` next state = `enable` & (`pwm_cnt` == 2^LEVEL_W-1).

## Timing
- `step` sampled at edge N: `level`/`cur_pat` update at edge N, and `led` reflects them from edge N+1. Latency is 1 cycle.
- PWM period is 2^LEVEL_W cycles (8 at default).
- Decay step period is DECAY_DIV × 2^LEVEL_W cycles (32 at default).
- Full fade from LEVEL_MAX to 0 takes LEVEL_MAX decay ticks. The first tick falls up to one decay period after the bit leaves `cur_pat`.
- `clear` asserted at any time, including mid-fade: all outputs are 0 immediately, with no clock edge required.
- On `clear` deassertion, counting starts with `pwm_cnt` = 0 on the first enabled edge.

## Configuration
- `LED_TRAIL_DECAY_EN` defined:
  - Trail behaviour as above.
- Undefined:
  - No `decay_cnt` and no decrement logic; `DECAY_DIV` is ignored.
  - On `step`, `level[i]` ← `pattern[i]` ? LEVEL_MAX : 0, so unlit bits turn off immediately.
  - PWM and `frame` are unchanged.

## Structure
- Package `led_trail_pkg` holds:
  - default constants `LED_W` = 8 and `LED_LEVEL_W` = 3;
  - typedef `led_level_t` (logic [LED_LEVEL_W-1:0]);
  - constant `LED_LEVEL_MAX`.
- Sub-module `trail_channel`: one per LED, generated WIDTH times.
  - Holds `level[i]`.
  - Performs load/decay/saturate.
  - Performs the duty compare against the shared `pwm_cnt`.
- The top module owns `pwm_cnt`, `decay_cnt`, `cur_pat` and `frame`.

## Test plan
- Async reset: run with `pattern` 8'h01, then assert `clear` mid-cycle. Expect `led` = 0 and `frame` = 0 before the next edge; after release, `led` stays 0 until the next `step`.
- Single dot: `enable` = 1, `step` with 8'h01. Expect `led[0]` = 1 on every cycle from N+1, other LEDs 0, and `frame` pulsing every 8 cycles.
- Fade: `step` 8'h01, then `step` 8'h02. Expect `led[1]` constant and `led[0]` at 6/8 duty after the first decay tick (≤32 cycles), then 5/8 and so on, reaching 0 % after 7 decay ticks (≤224 cycles).
- Collision: `step` 8'h01 on the same cycle as a decay tick, with `level[0]` = 3 beforehand. Expect `level[0]` = 7 (no decrement), while other nonzero levels decrement.
- Blanking: `enable` = 0 for 20 cycles mid-fade. Expect `led` = 0, no `frame` pulses and unchanged duty levels; after re-enable, duty resumes at the same level.
- `LED_TRAIL_DECAY_EN` undefined: `step` 8'h01 then 8'h02. Expect `led[0]` = 0 from the cycle after the second step, with no trail.
